// File: rtl/pid_channel_scheduler.sv
// pid_channel_scheduler
// Time-shares one PID datapath across N_CH control loops. Each channel keeps
// its own gains, 24-bit saturating integral and previous error. A tick
// snapshots setpoint, feedback and enables, then channels are processed
// round-robin. An enabled channel takes 4 cycles and a disabled one takes 1.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   tick                 sample strobe; starts a frame when idle
//   ch_en                per-channel enable (snapshotted at frame start)
//   setpoint, feedback   8 bits per channel, channel c at [8c+7:8c]
//   cfg_valid/cfg_ready  gain write handshake; ready is !busy
//   cfg_ch, cfg_sel      target channel; 0=Kp 1=Ki 2=Kd 3=clear integ/prev_err
//   cfg_data             gain value
//   control_out          registered per-channel outputs
//   out_valid, out_ch    one-cycle pulse and index when a channel updates
//   busy, frame_done     frame in progress / end-of-frame pulse
//   overrun              sticky: a tick arrived while busy
//
// state  | meaning
// IDLE   | waiting for tick; config writes accepted
// LOAD   | err = sp - fb for channel ch
// TERMS  | integral update (saturating) and derivative
// OUTPUT | sum, clamp to 0..255, write control_out, pulse out_valid
// STORE  | save prev_err, advance to next channel
// SKIP   | disabled channel: clear its state and output, advance
module pid_channel_scheduler #(
  parameter int         N_CH   = 4,
  parameter logic [7:0] KP_RST = 8'd2,
  parameter logic [7:0] KI_RST = 8'd1,
  parameter logic [7:0] KD_RST = 8'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_CH-1:0]     ch_en,
  input  logic [8*N_CH-1:0]   setpoint,
  input  logic [8*N_CH-1:0]   feedback,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [1:0]          cfg_sel,
  input  logic [7:0]          cfg_data,
  output logic [8*N_CH-1:0]   control_out,
  output logic                out_valid,
  output logic [2:0]          out_ch,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
  localparam logic signed [24:0] I_MAX = 25'sd8388607;
  localparam logic signed [24:0] I_MIN = -25'sd8388608;

  typedef enum logic [2:0] {IDLE, LOAD, TERMS, OUTPUT, STORE, SKIP} state_t;

  state_t                  state;
  logic [CW-1:0]           ch;
  logic [N_CH-1:0]         en_snap;
  logic [N_CH-1:0][7:0]    sp_snap, fb_snap;
  logic [N_CH-1:0][7:0]    kp_q, ki_q, kd_q, ctrl_q;
  logic signed [23:0]      integ_q    [N_CH];
  logic signed [15:0]      prev_err_q [N_CH];
  logic signed [15:0]      err_q;
  logic signed [16:0]      deriv_q;

  logic signed [8:0]       err_new;
  logic signed [24:0]      ki_prod, integ_sum;
  logic signed [23:0]      integ_next;
  logic signed [16:0]      deriv_new;
  logic signed [19:0]      p_term, i_term, d_term, sum;
  logic [7:0]              out_sat;
  logic                    cfg_hit;
  logic [CW-1:0]           cfg_idx;

  assign cfg_ready   = ~busy;
  assign control_out = ctrl_q;
  assign cfg_hit     = cfg_valid && !busy && (32'(cfg_ch) < N_CH);
  assign cfg_idx     = cfg_ch[CW-1:0];

  always_comb begin
    err_new   = $signed({1'b0, sp_snap[ch]}) - $signed({1'b0, fb_snap[ch]});
    ki_prod   = $signed({17'd0, ki_q[ch]}) * $signed({{9{err_q[15]}}, err_q});
    integ_sum = $signed({integ_q[ch][23], integ_q[ch]}) + ki_prod;
    if (integ_sum > I_MAX)
      integ_next = I_MAX[23:0];
    else if (integ_sum < I_MIN)
      integ_next = I_MIN[23:0];
    else
      integ_next = integ_sum[23:0];
    deriv_new = $signed({err_q[15], err_q}) - $signed({prev_err_q[ch][15], prev_err_q[ch]});
    // 20 bits holds the worst case of all three terms without overflow.
    p_term = $signed({12'd0, kp_q[ch]}) * $signed({{4{err_q[15]}}, err_q});
    i_term = $signed({{4{integ_q[ch][23]}}, integ_q[ch][23:8]});
    d_term = $signed({12'd0, kd_q[ch]}) * $signed({{3{deriv_q[16]}}, deriv_q});
    sum    = p_term + i_term + d_term;
    if (sum[19])
      out_sat = 8'd0;
    else if (sum > 20'sd255)
      out_sat = 8'hFF;
    else
      out_sat = sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      en_snap    <= '0;
      sp_snap    <= '0;
      fb_snap    <= '0;
      kp_q       <= {N_CH{KP_RST}};
      ki_q       <= {N_CH{KI_RST}};
      kd_q       <= {N_CH{KD_RST}};
      ctrl_q     <= '0;
      err_q      <= '0;
      deriv_q    <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        integ_q[i]    <= '0;
        prev_err_q[i] <= '0;
      end
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (tick && busy)
        overrun <= 1'b1;

      // Only possible while idle, so never collides with the FSM writes below.
      if (cfg_hit) begin
        case (cfg_sel)
          2'd0: kp_q[cfg_idx] <= cfg_data;
          2'd1: ki_q[cfg_idx] <= cfg_data;
          2'd2: kd_q[cfg_idx] <= cfg_data;
          default: begin
            integ_q[cfg_idx]    <= '0;
            prev_err_q[cfg_idx] <= '0;
          end
        endcase
      end

      case (state)
        IDLE: begin
          if (tick) begin
            sp_snap <= setpoint;
            fb_snap <= feedback;
            en_snap <= ch_en;
            ch      <= '0;
            busy    <= 1'b1;
            state   <= ch_en[0] ? LOAD : SKIP;
          end
        end
        LOAD: begin
          err_q <= {{7{err_new[8]}}, err_new};
          state <= TERMS;
        end
        TERMS: begin
          integ_q[ch] <= integ_next;
          deriv_q     <= deriv_new;
          state       <= OUTPUT;
        end
        OUTPUT: begin
          ctrl_q[ch] <= out_sat;
          out_valid  <= 1'b1;
          out_ch     <= 3'(ch);
          state      <= STORE;
        end
        STORE, SKIP: begin
          if (state == STORE) begin
            prev_err_q[ch] <= err_q;
          end else begin
            integ_q[ch]    <= '0;
            prev_err_q[ch] <= '0;
            ctrl_q[ch]     <= '0;
          end
          if (ch == LAST_CH) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            ch    <= ch + 1'b1;
            state <= en_snap[ch + 1'b1] ? LOAD : SKIP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Randomized and directed bench for pid_channel_scheduler against a
// per-frame arithmetic reference model.
module tb_pid_channel_scheduler;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst, tick, cfg_valid;
  logic [N-1:0]     ch_en;
  logic [8*N-1:0]   setpoint, feedback;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [1:0]       cfg_sel;
  logic [7:0]       cfg_data;
  logic [8*N-1:0]   control_out;
  logic             out_valid;
  logic [2:0]       out_ch;
  logic             busy, frame_done, overrun;

  pid_channel_scheduler #(.N_CH(N), .KP_RST(8'd2), .KI_RST(8'd1), .KD_RST(8'd1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ch_en(ch_en),
    .setpoint(setpoint), .feedback(feedback),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .control_out(control_out),
    .out_valid(out_valid), .out_ch(out_ch), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int kp [N], ki [N], kd [N], integ [N], prev [N], ctrl [N];
  bit ovr;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      kp[c] = 2; ki[c] = 1; kd[c] = 1;
      integ[c] = 0; prev[c] = 0; ctrl[c] = 0;
    end
    ovr = 0;
  endtask

  function automatic int sat_integ(input int v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  task automatic cfg_write(input int c, input int sel, input int data);
    int n;
    @(negedge clk);
    cfg_ch = 3'(c); cfg_sel = 2'(sel); cfg_data = 8'(data); cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_accept", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("cfg_land_idle", busy, 0);
    if (c < N) begin
      case (sel)
        0: kp[c] = data;
        1: ki[c] = data;
        2: kd[c] = data;
        default: begin integ[c] = 0; prev[c] = 0; end
      endcase
    end
  endtask

  // One frame: tick, then watch every cycle until frame_done. dup_at injects
  // a second tick sampled at edge E+dup_at; abort_at pulses rst at E+abort_at.
  task automatic run_frame(input int dup_at, input int abort_at);
    int exp_t [N];
    int exp_v [N];
    int t, len, nxt, k, err, d, s, o;
    bit done, aborted;
    t = 0;
    for (int c = 0; c < N; c++) begin
      if (ch_en[c]) begin
        err = int'(setpoint[8*c +: 8]) - int'(feedback[8*c +: 8]);
        integ[c] = sat_integ(integ[c] + ki[c] * err);
        d = err - prev[c];
        s = kp[c] * err + (integ[c] >>> 8) + kd[c] * d;
        o = (s < 0) ? 0 : (s > 255) ? 255 : s;
        exp_v[c] = o; exp_t[c] = t + 3; t += 4;
        prev[c] = err; ctrl[c] = o;
      end else begin
        integ[c] = 0; prev[c] = 0; ctrl[c] = 0;
        exp_v[c] = 0; exp_t[c] = -1; t += 1;
      end
    end
    len = t;
    if (dup_at >= 1 && dup_at <= len) ovr = 1;

    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1;
    chk("busy_start", busy, 1);
    chk("cfg_ready_busy", cfg_ready, 0);
    nxt = 0; done = 0; aborted = 0;
    for (k = 1; k <= len + 4 && !done; k++) begin
      @(negedge clk);
      tick = (k == dup_at);
      rst  = (k == abort_at);
      @(posedge clk); #1;
      if (k == abort_at) begin
        model_reset();
        for (int c = 0; c < N; c++) begin
          chk("rst_ctrl", control_out[8*c +: 8], 0);
          chk("rst_integ", dut.integ_q[c], 0);
        end
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        done = 1; aborted = 1;
      end else begin
        if (out_valid) begin
          while (nxt < N && !ch_en[nxt]) nxt++;
          if (nxt < N) begin
            chk("ov_ch", out_ch, nxt);
            chk("ov_time", k, exp_t[nxt]);
            chk("ov_val", control_out[8*nxt +: 8], exp_v[nxt]);
            nxt++;
          end else begin
            chk("ov_spurious", out_valid, 0);
          end
        end
        if (frame_done) begin
          chk("frame_len", k, len);
          chk("busy_end", busy, 0);
          chk("cfg_ready_end", cfg_ready, 1);
          done = 1;
        end else begin
          chk("busy_mid", busy, 1);
        end
      end
    end
    @(negedge clk);
    tick = 1'b0; rst = 1'b0;
    chk("frame_done_seen", done, 1);
    if (!aborted) begin
      while (nxt < N && !ch_en[nxt]) nxt++;
      chk("ov_count", nxt, N);
      for (int c = 0; c < N; c++)
        chk("ctrl", control_out[8*c +: 8], ctrl[c]);
      chk("overrun", overrun, ovr);
    end
  endtask

  task automatic set_ch(input int c, input int sp, input int fb);
    setpoint[8*c +: 8] = 8'(sp);
    feedback[8*c +: 8] = 8'(fb);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_sel = '0;
    cfg_data = '0; ch_en = '1; setpoint = '0; feedback = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", control_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cfg_ready", cfg_ready, 1);
    chk("reset_overrun", overrun, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    @(negedge clk); rst = 1'b0;

    // Basic PID step then steady error.
    set_ch(0, 100, 90);
    run_frame(0, 0);
    chk("first_frame_30", control_out[7:0], 30);
    run_frame(0, 0);
    chk("second_frame_20", control_out[7:0], 20);

    // Clamp high and low.
    set_ch(0, 0, 200);
    set_ch(1, 255, 0);
    run_frame(0, 0);
    chk("clamp_low", control_out[7:0], 0);
    chk("clamp_high", control_out[15:8], 255);

    // Disabled channels, then re-enable.
    ch_en = 4'b1010;
    run_frame(0, 0);
    ch_en = 4'b1111;
    set_ch(0, 100, 90);
    run_frame(0, 0);

    // Config write stalls while busy and lands afterwards.
    fork
      run_frame(0, 0);
      begin
        repeat (3) @(negedge clk);
        chk("cfg_ready_stall", cfg_ready, 0);
        cfg_write(0, 0, 5);
      end
    join
    run_frame(0, 0);

    // Tick while busy: sticky overrun, frame timing unchanged.
    run_frame(3, 0);

    // Randomized frames and configuration writes.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write($urandom_range(0, 7), $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7));
      end
      for (int c = 0; c < N; c++)
        set_ch(c, $urandom_range(0, 255), $urandom_range(0, 255));
      ch_en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      run_frame(($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0, 0);
    end

    // Integral saturation.
    cfg_write(0, 3, 0);
    cfg_write(0, 1, 255);
    ch_en = 4'b0001;
    set_ch(0, 255, 0);
    for (int f = 0; f < 200; f++)
      run_frame(0, 0);
    chk("integ_pin", dut.integ_q[0], 8388607);
    chk("integ_model_pin", integ[0], 8388607);
    chk("sat_out", control_out[7:0], 255);

    // Reset in the middle of channel 2.
    ch_en = 4'b1111;
    run_frame(0, 10);
    for (int c = 0; c < N; c++) set_ch(c, 0, 0);
    set_ch(0, 100, 90);
    run_frame(0, 0);
    chk("post_rst_30", control_out[7:0], 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pid_channel_scheduler.md
# pid_channel_scheduler

Time-shares one PID compute datapath across `N_CH` control loops. Per-channel error history, integral and gains live in register banks, and channels are processed round-robin once per sample tick. The block sits between the chip-level setpoint/feedback inputs and the per-channel control outputs. It replaces one-PID-per-loop instantiation when several loops run at a low sample rate.

## Interface
Parameters:
- `N_CH`, 4: number of channels (2..8).
- `KP_RST`, 2: reset value of every channel's Kp.
- `KI_RST`, 1: reset value of every channel's Ki.
- `KD_RST`, 1: reset value of every channel's Kd.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tick`  in  1  sample strobe; starts a frame when idle.
- `ch_en`  in  N_CH  per-channel enable, sampled at frame start.
- `setpoint`  in  8*N_CH  unsigned setpoints; channel c is bits [8c+7:8c].
- `feedback`  in  8*N_CH  unsigned measured values, same packing.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config accepted when high; equals !busy.
- `cfg_ch`  in  3  target channel; values ≥ N_CH are ignored.
- `cfg_sel`  in  2  register select: 0=Kp, 1=Ki, 2=Kd, 3=clear integral and prev_error.
- `cfg_data`  in  8  unsigned gain value; ignored for sel=3.
- `control_out`  out  8*N_CH  registered per-channel outputs.
- `out_valid`  out  1  one-cycle pulse when a channel's output updates.
- `out_ch`  out  3  channel index qualified by `out_valid`.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `overrun`  out  1  sticky flag; a tick arrived while busy; cleared only by `rst`.

## Operation
- States: IDLE, LOAD, TERMS, OUTPUT, STORE, SKIP. `ch` is the channel counter.
- IDLE + tick:
  - Snapshot `setpoint`, `feedback` and `ch_en` for all channels.
  - Set ch=0, busy=1.
  - Go to LOAD if ch_en[0], otherwise SKIP.
- LOAD: err = {1'b0,sp} − {1'b0,fb}, a 9-bit signed value in −255..255, held in a 16-bit register.
- TERMS:
  - integ[ch] += Ki*err. Integral is 24-bit signed and saturates to [−2^23, 2^23−1]; it never wraps.
  - deriv = err − prev_err[ch].
- OUTPUT:
  - sum = Kp*err + (integ[ch] >>> 8) + Kd*deriv, computed at 20-bit signed width with no intermediate overflow.
  - The clamp uses this same-cycle sum, never a stale value: <0 → 0, >255 → 255, else sum[7:0].
  - Writes control_out[ch], pulses out_valid, drives out_ch=ch.
- STORE: prev_err[ch] = err. Then ch++; if ch wraps past N_CH−1, go to IDLE, otherwise go to LOAD or SKIP for the next channel.
- SKIP (disabled channel): clears integ[ch] and prev_err[ch], sets control_out[ch]=0, no out_valid pulse. Advances exactly as STORE does.
- Gains are unsigned 8-bit. The channel index ch applies to integ, prev_err and gains alike.
- A config write is accepted only when cfg_valid && cfg_ready. It takes effect the next cycle.
- A tick while busy (including the final STORE/SKIP cycle) is dropped and sets overrun.
- `rst` during a frame aborts it. All registers return to reset values on the next edge.

## Timing
- Reset values:
  - control_out = 0 for all channels.
  - out_valid=0, out_ch=0, busy=0, frame_done=0, overrun=0, cfg_ready=1.
  - integ=0, prev_err=0, gains = KP_RST/KI_RST/KD_RST.
- Tick sampled high at edge E. busy=1 and cfg_ready=0 from E.
- Enabled channel c, all earlier channels enabled: control_out[c] and out_valid valid after edge E+3+4c.
- Each enabled channel costs 4 cycles; each disabled channel costs 1 cycle.
- Last channel: busy=0 and frame_done=1 after its STORE/SKIP edge, i.e. E+4·N_CH with all channels enabled.
- Earliest next accepted tick is at that edge +1.

## Test plan
- Defaults, sp0=100, fb0=90, tick → control_out[0]=30 (err 10, integ 10, deriv 10) after E+3. Second tick with the same inputs → 20 (integ 20, deriv 0).
- sp=255, fb=0 → control_out=255 (clamp high). sp=0, fb=200 → control_out=0 (clamp low, negative error handled signed).
- Set Ki=255, hold err=255 for ~200 frames → integral pins at 2^23−1 with no sign flip, and control_out stays 255.
- Tick again 3 cycles after the first → overrun=1, frame timing unchanged, frame_done after E+16 (N_CH=4). A cfg write during busy stalls (cfg_ready=0) and lands after frame_done.
- ch_en=4'b1010 → channels 0 and 2 output 0 with no out_valid, frame lasts 10 cycles. Re-enabling a channel starts it from integ=0.
- Assert rst mid-frame at channel 2 → all outputs and integrals are 0 next cycle, busy=0, gains back to 2/1/1.
